uart_tx: RTL and testbench

UART transmitter that serializes one parallel data word per frame onto the TX line as start bit, DATA_WIDTH data bits LSB-first, optional parity bit, and one stop bit. It is the transmit-side counterpart of the receive deserializer in the UART interface and runs on the TX bit clock, one bit per CLK cycle. A valid/ready handshake with the upstream data source allows back-to-back frames with no idle gap.

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_serializer.sv | 58 +++++
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmitter.
// Optional parity support is enabled by defining UART_TX_PARITY_EN.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load-and-shift register with a data-bit index counter for the UART transmitter.
// ser_bit is the next bit to present; ser_done flags that the last data bit is on the line.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  armed_q, armed_d;

  // The first shift after a load puts bit 0 on the line, so it restarts the
  // index at 0 instead of advancing it; later shifts advance and saturate.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      shift_d = data;
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (shift_en) begin
      shift_d = shift_q >> 1;
      armed_d = 1'b0;
      if (armed_q) begin
        cnt_d = '0;
      end else if (cnt_q != LAST_IDX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign ser_bit  = shift_q[0];
  assign ser_done = !armed_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit, one bit per CLK.
// Define UART_TX_PARITY_EN to include the parity state and generator.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_READY,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  import uart_tx_pkg::*;

  state_t state_q, state_d;
  logic   tx_out_q, tx_out_d;
  logic   busy_q, busy_d;
  logic   tx_ready;
  logic   accept;
  logic   shift_en;
  logic   ser_bit;
  logic   ser_done;

`ifdef UART_TX_PARITY_EN
  logic   par_en_q, par_en_d;
  logic   par_bit_q, par_bit_d;
`else
  logic   unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  assign tx_ready = (state_q == IDLE) || (state_q == STOP);
  assign accept   = DATA_VALID && tx_ready;

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_serializer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (accept),
    .shift_en(shift_en),
    .data    (P_DATA),
    .ser_bit (ser_bit),
    .ser_done(ser_done)
  );

  // Outputs are computed for the state being entered so TX_OUT/BUSY stay registered.
  always_comb begin
    state_d  = state_q;
    tx_out_d = tx_out_q;
    busy_d   = busy_q;
    shift_en = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    if (accept) begin
      par_en_d  = PAR_EN;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
    end
`endif
    case (state_q)
      IDLE, STOP: begin
        state_d  = IDLE;
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b0;
        if (accept) begin
          state_d  = START;
          tx_out_d = START_BIT;
          busy_d   = 1'b1;
        end
      end
      START: begin
        state_d  = DATA;
        tx_out_d = ser_bit;
        busy_d   = 1'b1;
        shift_en = 1'b1;
      end
      DATA: begin
        busy_d = 1'b1;
        if (!ser_done) begin
          tx_out_d = ser_bit;
          shift_en = 1'b1;
        end else begin
          state_d  = STOP;
          tx_out_d = STOP_BIT;
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d  = PARITY;
            tx_out_d = par_bit_q;
          end
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        state_d  = STOP;
        tx_out_d = STOP_BIT;
        busy_d   = 1'b1;
      end
`endif
      default: begin
        state_d  = IDLE;
        tx_out_d = IDLE_LEVEL;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_out_q  <= IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tx_out_q  <= tx_out_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  assign TX_READY = tx_ready;
  assign TX_OUT   = tx_out_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected serial frames come from a bit-list model.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          DATA_VALID = 1'b0;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          TX_READY;
    logic          TX_OUT;
    logic          BUSY;

    int errors = 0;
    int checks = 0;

    bit   exp_q[$];
    logic obs_tx[$];
    logic obs_busy[$];
    logic obs_rdy[$];

    always #5 CLK = ~CLK;

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .DATA_VALID(DATA_VALID),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_READY  (TX_READY),
        .TX_OUT    (TX_OUT),
        .BUSY      (BUSY)
    );

    task automatic model_frame(input logic [DW-1:0] d, input bit pen, input bit ptyp);
        int ones;
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (PAR_ON && pen) exp_q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
        exp_q.push_back(1'b1);
    endtask

    task automatic capture(input int n);
        obs_tx.delete();
        obs_busy.delete();
        obs_rdy.delete();
        repeat (n) begin
            @(negedge CLK);
            obs_tx.push_back(TX_OUT);
            obs_busy.push_back(BUSY);
            obs_rdy.push_back(TX_READY);
        end
    endtask

    task automatic offer(input logic [DW-1:0] d, input bit pen, input bit ptyp);
        P_DATA = d;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if ({TX_OUT, BUSY, TX_READY} !== 3'b101) begin
            errors++;
            $display("FAIL reset_held tx/busy/rdy got %b%b%b exp 101", TX_OUT, BUSY, TX_READY);
        end
        RST = 1'b1;
        capture(20);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({obs_tx[k], obs_busy[k], obs_rdy[k]} !== 3'b101) begin
                errors++;
                $display("FAIL reset_idle cycle %0d tx/busy/rdy got %b%b%b exp 101",
                         k, obs_tx[k], obs_busy[k], obs_rdy[k]);
            end
        end
    endtask

    task automatic test_basic();
        exp_q.delete();
        model_frame(8'hA5, 1'b0, 1'b0);
        checks++;
        if (TX_READY !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready got %b exp 1", TX_READY);
        end
        offer(8'hA5, 1'b0, 1'b0);
        capture(exp_q.size() + 1);
        for (int k = 0; k <= exp_q.size(); k++) begin
            bit et, eb, er;
            et = (k < exp_q.size()) ? exp_q[k] : 1'b1;
            eb = (k < exp_q.size());
            er = (k >= exp_q.size() - 1);
            checks++;
            if ({obs_tx[k], obs_busy[k], obs_rdy[k]} !== {et, eb, er}) begin
                errors++;
                $display("FAIL basic_a5 cycle %0d tx/busy/rdy got %b%b%b exp %b%b%b",
                         k, obs_tx[k], obs_busy[k], obs_rdy[k], et, eb, er);
            end
        end
    endtask

    task automatic test_parity();
        logic [DW-1:0] words[3] = '{8'hA5, 8'h07, 8'h07};
        bit            typs[3]  = '{1'b0, 1'b0, 1'b1};
        for (int f = 0; f < 3; f++) begin
            exp_q.delete();
            model_frame(words[f], 1'b1, typs[f]);
            checks++;
            if (exp_q.size() != (PAR_ON ? DW + 3 : DW + 2)) begin
                errors++;
                $display("FAIL parity_len frame %0d got %0d", f, exp_q.size());
            end
            offer(words[f], 1'b1, typs[f]);
            capture(exp_q.size() + 1);
            for (int k = 0; k <= exp_q.size(); k++) begin
                bit et, eb, er;
                et = (k < exp_q.size()) ? exp_q[k] : 1'b1;
                eb = (k < exp_q.size());
                er = (k >= exp_q.size() - 1);
                checks++;
                if ({obs_tx[k], obs_busy[k], obs_rdy[k]} !== {et, eb, er}) begin
                    errors++;
                    $display("FAIL parity frame %0d cycle %0d tx/busy/rdy got %b%b%b exp %b%b%b",
                             f, k, obs_tx[k], obs_busy[k], obs_rdy[k], et, eb, er);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int len1, total;
        exp_q.delete();
        model_frame(8'h3C, 1'b0, 1'b0);
        len1 = exp_q.size();
        model_frame(8'hC3, 1'b0, 1'b0);
        total = exp_q.size();
        P_DATA = 8'h3C;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 P_DATA = 8'hC3;
        for (int k = 0; k <= total; k++) begin
            bit et, eb, er;
            @(negedge CLK);
            et = (k < total) ? exp_q[k] : 1'b1;
            eb = (k < total);
            er = (k == len1 - 1) || (k >= total - 1);
            checks++;
            if ({TX_OUT, BUSY, TX_READY} !== {et, eb, er}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d tx/busy/rdy got %b%b%b exp %b%b%b",
                         k, TX_OUT, BUSY, TX_READY, et, eb, er);
            end
            if (k == len1) DATA_VALID = 1'b0;
        end
    endtask

    task automatic test_stability();
        exp_q.delete();
        model_frame(8'h00, 1'b0, 1'b0);
        P_DATA = 8'h00;
        PAR_EN = 1'b0;
        PAR_TYP = 1'b0;
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
        P_DATA = 8'hFF;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
        capture(exp_q.size() + 1);
        for (int k = 0; k <= exp_q.size(); k++) begin
            bit et, eb;
            et = (k < exp_q.size()) ? exp_q[k] : 1'b1;
            eb = (k < exp_q.size());
            checks++;
            if ({obs_tx[k], obs_busy[k]} !== {et, eb}) begin
                errors++;
                $display("FAIL stability cycle %0d tx/busy got %b%b exp %b%b",
                         k, obs_tx[k], obs_busy[k], et, eb);
            end
        end
    endtask

    task automatic test_midframe_reset();
        exp_q.delete();
        model_frame(8'hA5, 1'b0, 1'b0);
        offer(8'hA5, 1'b0, 1'b0);
        capture(6);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({obs_tx[k], obs_busy[k]} !== {exp_q[k], 1'b1}) begin
                errors++;
                $display("FAIL midframe_pre cycle %0d tx/busy got %b%b exp %b1",
                         k, obs_tx[k], obs_busy[k], exp_q[k]);
            end
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({TX_OUT, BUSY, TX_READY} !== 3'b101) begin
            errors++;
            $display("FAIL midframe_async tx/busy/rdy got %b%b%b exp 101", TX_OUT, BUSY, TX_READY);
        end
        @(negedge CLK);
        RST = 1'b1;
        capture(3);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({obs_tx[k], obs_busy[k], obs_rdy[k]} !== 3'b101) begin
                errors++;
                $display("FAIL midframe_idle cycle %0d tx/busy/rdy got %b%b%b exp 101",
                         k, obs_tx[k], obs_busy[k], obs_rdy[k]);
            end
        end
        exp_q.delete();
        model_frame(8'h55, 1'b0, 1'b0);
        offer(8'h55, 1'b0, 1'b0);
        capture(exp_q.size() + 1);
        for (int k = 0; k <= exp_q.size(); k++) begin
            bit et, eb;
            et = (k < exp_q.size()) ? exp_q[k] : 1'b1;
            eb = (k < exp_q.size());
            checks++;
            if ({obs_tx[k], obs_busy[k]} !== {et, eb}) begin
                errors++;
                $display("FAIL midframe_next cycle %0d tx/busy got %b%b exp %b%b",
                         k, obs_tx[k], obs_busy[k], et, eb);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            logic [DW-1:0] d;
            bit pen, ptyp;
            d = DW'($urandom);
            pen = 1'($urandom);
            ptyp = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            exp_q.delete();
            model_frame(d, pen, ptyp);
            checks++;
            if (TX_READY !== 1'b1) begin
                errors++;
                $display("FAIL random_ready frame %0d got %b exp 1", f, TX_READY);
            end
            offer(d, pen, ptyp);
            capture(exp_q.size() + 1);
            for (int k = 0; k <= exp_q.size(); k++) begin
                bit et, eb, er;
                et = (k < exp_q.size()) ? exp_q[k] : 1'b1;
                eb = (k < exp_q.size());
                er = (k >= exp_q.size() - 1);
                checks++;
                if ({obs_tx[k], obs_busy[k], obs_rdy[k]} !== {et, eb, er}) begin
                    errors++;
                    $display("FAIL random frame %0d data %h cycle %0d tx/busy/rdy got %b%b%b exp %b%b%b",
                             f, d, k, obs_tx[k], obs_busy[k], obs_rdy[k], et, eb, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_stability();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
